frame_sequencer: RTL and testbench



---
 rtl/frame_sequencer_if.sv | 23 ++
 rtl/frame_sequencer.sv | 109 ++++++++++
 tb/tb_frame_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// Bus between the $4017/$4015 register decoder and the frame sequencer.
// The master drives the CPU-side strobes; the slave returns the low-rate strobes and status.
interface frame_sequencer_if;
  logic       clk_en;
  logic       reg_4017_wr;
  logic [7:0] reg_4017_data;
  logic       irq_ack;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       frame_irq;
  logic       mode;
  logic [2:0] step;

  modport master (
    output clk_en, reg_4017_wr, reg_4017_data, irq_ack,
    input  enable_240hz, enable_120hz, frame_irq, mode, step
  );

  modport slave (
    input  clk_en, reg_4017_wr, reg_4017_data, irq_ack,
    output enable_240hz, enable_120hz, frame_irq, mode, step
  );
endinterface

// File: rtl/frame_sequencer.sv
// APU frame counter: divides the CPU-rate tick into 4-step/5-step quarter/half-frame
// strobes and raises the frame interrupt at the end of each 4-step sequence.
module frame_sequencer #(
  parameter int QUARTER_DIV = 7457,
  parameter int DIV_WIDTH   = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  frame_sequencer_if.slave   bus
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(QUARTER_DIV - 1);

  logic [DIV_WIDTH-1:0] div_reg, div_next;
  logic [2:0]           step_reg, step_next;
  logic                 mode_reg, mode_next;
  logic                 inhibit_reg, inhibit_next;
  logic                 irq_reg, irq_next;
  logic                 quarter_reg, quarter_next;
  logic                 half_reg, half_next;

  logic step_event;
  logic last_step;

  assign step_event = bus.clk_en && (div_reg == DIV_LAST);
  assign last_step  = mode_reg ? (step_reg == 3'd4) : (step_reg == 3'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg     <= '0;
      step_reg    <= 3'd0;
      mode_reg    <= 1'b0;
      inhibit_reg <= 1'b0;
      irq_reg     <= 1'b0;
      quarter_reg <= 1'b0;
      half_reg    <= 1'b0;
    end else begin
      div_reg     <= div_next;
      step_reg    <= step_next;
      mode_reg    <= mode_next;
      inhibit_reg <= inhibit_next;
      irq_reg     <= irq_next;
      quarter_reg <= quarter_next;
      half_reg    <= half_next;
    end
  end

  // A register write restarts the sequence and swallows any coincident step event.
  always_comb begin
    div_next     = div_reg;
    step_next    = step_reg;
    mode_next    = mode_reg;
    inhibit_next = inhibit_reg;
    if (bus.reg_4017_wr) begin
      div_next     = '0;
      step_next    = 3'd0;
      mode_next    = bus.reg_4017_data[7];
      inhibit_next = bus.reg_4017_data[6];
    end else if (bus.clk_en) begin
      if (step_event) begin
        div_next  = '0;
        step_next = last_step ? 3'd0 : step_reg + 3'd1;
      end else begin
        div_next = div_reg + DIV_WIDTH'(1);
      end
    end
  end

  always_comb begin
    quarter_next = 1'b0;
    half_next    = 1'b0;
    irq_next     = irq_reg & ~bus.irq_ack;
    if (bus.reg_4017_wr) begin
      // Selecting 5-step mode clocks the units immediately.
      quarter_next = bus.reg_4017_data[7];
      half_next    = bus.reg_4017_data[7];
      if (bus.reg_4017_data[6]) begin
        irq_next = 1'b0;
      end
    end else if (step_event) begin
      case (step_reg)
        3'd0, 3'd2: quarter_next = 1'b1;
        3'd1: begin
          quarter_next = 1'b1;
          half_next    = 1'b1;
        end
        3'd3: begin
          quarter_next = ~mode_reg;
          half_next    = ~mode_reg;
          if (!mode_reg && !inhibit_reg) begin
            irq_next = 1'b1;
          end
        end
        3'd4: begin
          quarter_next = 1'b1;
          half_next    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.enable_240hz = quarter_reg;
  assign bus.enable_120hz = half_reg;
  assign bus.frame_irq    = irq_reg;
  assign bus.mode         = mode_reg;
  assign bus.step         = step_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with QUARTER_DIV=4: stimulus queues the expected
// pulses, a monitor pops and compares each strobe the sequencer emits.
module tb_frame_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Expected pulse: {half, irq, mode, step[2:0]}
  logic [5:0] exp_q[$];

  frame_sequencer_if bus();

  frame_sequencer #(.QUARTER_DIV(4), .DIV_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic en, input logic wr, input logic [7:0] d, input logic ack);
    @(negedge clk);
    bus.clk_en        = en;
    bus.reg_4017_wr   = wr;
    bus.reg_4017_data = d;
    bus.irq_ack       = ack;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic expect_pulse(input logic h, input logic irq, input logic md, input logic [2:0] st);
    exp_q.push_back({h, irq, md, st});
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && (bus.enable_240hz || bus.enable_120hz)) begin
      $display("pulse q=%0b h=%0b irq=%0b mode=%0b step=%0d",
               bus.enable_240hz, bus.enable_120hz, bus.frame_irq, bus.mode, bus.step);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {1'b0, bus.enable_240hz, bus.enable_120hz, bus.frame_irq,
              bus.mode, bus.step}, 8'h00);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check("pulse", {1'b0, bus.enable_240hz, bus.enable_120hz, bus.frame_irq, bus.mode, bus.step},
              {2'b01, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clk_en        = 1'b0;
    bus.reg_4017_wr   = 1'b0;
    bus.reg_4017_data = 8'h00;
    bus.irq_ack       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {1'b0, bus.enable_240hz, bus.enable_120hz, bus.frame_irq, bus.mode, bus.step}, 8'h00);
    rst_n = 1'b1;

    // 4-step sequence from reset
    expect_pulse(1'b0, 1'b0, 1'b0, 3'd1);
    expect_pulse(1'b1, 1'b0, 1'b0, 3'd2);
    expect_pulse(1'b0, 1'b0, 1'b0, 3'd3);
    expect_pulse(1'b1, 1'b1, 1'b0, 3'd0);
    tick(16);
    idle();
    check("irq_set_mode0", {7'd0, bus.frame_irq}, 8'd1);
    idle();
    check("irq_stays_high", {7'd0, bus.frame_irq}, 8'd1);

    // Acknowledge, then ack coincident with the 8th step event
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    idle();
    check("irq_ack_clear", {7'd0, bus.frame_irq}, 8'd0);
    expect_pulse(1'b0, 1'b0, 1'b0, 3'd1);
    expect_pulse(1'b1, 1'b0, 1'b0, 3'd2);
    expect_pulse(1'b0, 1'b0, 1'b0, 3'd3);
    expect_pulse(1'b1, 1'b1, 1'b0, 3'd0);
    tick(15);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    idle();
    check("ack_vs_set", {7'd0, bus.frame_irq}, 8'd1);

    // Advance to step 2, clear IRQ, then switch to 5-step mid-sequence
    expect_pulse(1'b0, 1'b1, 1'b0, 3'd1);
    expect_pulse(1'b1, 1'b1, 1'b0, 3'd2);
    tick(10);
    check("mid_step", {5'd0, bus.step}, 8'd2);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    expect_pulse(1'b1, 1'b0, 1'b1, 3'd0);
    drive(1'b1, 1'b1, 8'h80, 1'b0);
    idle();
    check("write80_step", {5'd0, bus.step}, 8'd0);
    expect_pulse(1'b0, 1'b0, 1'b1, 3'd1);
    expect_pulse(1'b1, 1'b0, 1'b1, 3'd2);
    expect_pulse(1'b0, 1'b0, 1'b1, 3'd3);
    expect_pulse(1'b1, 1'b0, 1'b1, 3'd0);
    tick(20);
    idle();
    check("mode1_no_irq", {6'd0, bus.mode, bus.frame_irq}, 8'b10);

    // Back to 4-step, raise IRQ, then inhibit it
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    expect_pulse(1'b0, 1'b0, 1'b0, 3'd1);
    expect_pulse(1'b1, 1'b0, 1'b0, 3'd2);
    expect_pulse(1'b0, 1'b0, 1'b0, 3'd3);
    expect_pulse(1'b1, 1'b1, 1'b0, 3'd0);
    tick(16);
    idle();
    check("irq_before_inhibit", {6'd0, bus.mode, bus.frame_irq}, 8'b01);
    drive(1'b0, 1'b1, 8'h40, 1'b0);
    idle();
    check("inhibit_clears_irq", {7'd0, bus.frame_irq}, 8'd0);
    expect_pulse(1'b0, 1'b0, 1'b0, 3'd1);
    expect_pulse(1'b1, 1'b0, 1'b0, 3'd2);
    expect_pulse(1'b0, 1'b0, 1'b0, 3'd3);
    expect_pulse(1'b1, 1'b0, 1'b0, 3'd0);
    tick(16);
    idle();
    check("inhibited_wrap", {7'd0, bus.frame_irq}, 8'd0);

    // Write coincident with a pending step event discards the event
    tick(3);
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    idle();
    check("write_vs_event_step", {5'd0, bus.step}, 8'd0);
    tick(3);
    idle();
    check("no_early_event", {5'd0, bus.step}, 8'd0);
    expect_pulse(1'b0, 1'b0, 1'b0, 3'd1);
    tick(1);
    idle();
    check("event_after_div", {5'd0, bus.step}, 8'd1);

    // Asynchronous reset between steps with IRQ pending
    expect_pulse(1'b1, 1'b0, 1'b0, 3'd2);
    expect_pulse(1'b0, 1'b0, 1'b0, 3'd3);
    expect_pulse(1'b1, 1'b1, 1'b0, 3'd0);
    tick(14);
    idle();
    check("irq_before_reset", {7'd0, bus.frame_irq}, 8'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", {1'b0, bus.enable_240hz, bus.enable_120hz, bus.frame_irq, bus.mode, bus.step}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    expect_pulse(1'b0, 1'b0, 1'b0, 3'd1);
    tick(4);
    idle();
    idle();
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
